// File: rtl/clk_div_switch_if.sv
// clk_div_switch_if: control, status and clock-out signals of clk_div_switch.
//   master modport : request side (drives clk_en, div_req, div_ratio)
//   slave modport  : divider side (drives busy, div_ack, cur_ratio, rise_stb, clk_o)
// All signals belong to the source clock domain except clk_o, which is the divided clock.
interface clk_div_switch_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             clk_en;     // level: 1 = run, 0 = stop at the next period boundary
  logic             div_req;    // ratio change request, sampled while busy = 0
  logic [CNT_W-1:0] div_ratio;  // requested ratio, captured with div_req
  logic             busy;       // request captured, not yet applied
  logic             div_ack;    // one-cycle pulse when the new ratio takes effect
  logic [CNT_W-1:0] cur_ratio;  // ratio currently in effect
  logic             rise_stb;   // one-cycle pulse on the cycle clk_o goes high
  logic             clk_o;      // divided clock

  modport master (
    output clk_en, div_req, div_ratio,
    input  busy, div_ack, cur_ratio, rise_stb, clk_o
  );

  modport slave (
    input  clk_en, div_req, div_ratio,
    output busy, div_ack, cur_ratio, rise_stb, clk_o
  );
endinterface

// File: rtl/clk_div_switch.sv
// clk_div_switch: glitch-free programmable clock divider.
//   Divides clk by a run-time ratio R (2..2^CNT_W-1). clk_o is high for H = R>>1 cycles and
//   low for R-H cycles. Ratio changes and stop requests take effect only on the last low cycle
//   of a period, so every high and low phase belongs to exactly one ratio's period.
// Ports:
//   clk  : source clock (posedge; negedge only with CLK_DIV_ODD_DUTY50_EN)
//   rst  : asynchronous, active-high reset
//   bus  : clk_div_switch_if.slave (clk_en, div_req, div_ratio in; busy, div_ack, cur_ratio,
//          rise_stb, clk_o out)
// Parameters:
//   CNT_W     : width of ratio and period counter
//   DEF_RATIO : ratio in effect after reset (0/1 clamp to 2)
// Registers update with zero delay; no simulation-only assignment delay is modelled.
// Optional feature (macro CLK_DIV_ODD_DUTY50_EN): for odd R a negedge flop extends the high
//   phase by half a cycle, giving an exact 50% duty cycle. Undefined: odd R is low-biased.
module clk_div_switch #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEF_RATIO = 4
) (
  input logic              clk,
  input logic              rst,
  clk_div_switch_if.slave  bus
);

  typedef enum logic [0:0] {StStop, StRun} state_e;

  localparam logic [CNT_W-1:0] Two      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DefRatio = (DEF_RATIO < 2) ? Two : CNT_W'(DEF_RATIO);

  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
    return (r < Two) ? Two : r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             rise_q, rise_d;
  logic             boundary;
  logic             apply;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    apply    = 1'b0;
    boundary = (state_q == StRun) && (cnt_q == (cur_q - CNT_W'(1)));

    unique case (state_q)
      StStop: begin
        cnt_d = '0;
        // No clock activity to protect, so a pending ratio applies immediately.
        apply = busy_q;
        if (bus.clk_en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (boundary) begin
          cnt_d = '0;
          apply = busy_q;
          if (!bus.clk_en) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StStop;
        cnt_d   = '0;
      end
    endcase

    if (apply) begin
      cur_d  = pend_q;
      busy_d = 1'b0;
      ack_d  = 1'b1;
    end

    // apply needs busy_q = 1, so capture and apply never coincide; a request arriving on a
    // boundary cycle therefore waits for the following boundary.
    if (!busy_q && bus.div_req) begin
      pend_d = clamp_ratio(bus.div_ratio);
      busy_d = 1'b1;
    end

    // Phase computed from the ratio that governs the next cycle.
    clk_d  = (state_d == StRun) && (cnt_d < (cur_d >> 1));
    rise_d = (state_d == StRun) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStop;
      cnt_q   <= '0;
      cur_q   <= DefRatio;
      pend_q  <= '0;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rise_q  <= rise_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.div_ack   = ack_q;
  assign bus.cur_ratio = cur_q;
  assign bus.rise_stb  = rise_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
  // Half-cycle extension of the high phase for odd ratios: the negedge copy of clk_q holds
  // clk_o high until the middle of the first low cycle.
  logic neg_q, neg_d;

  always_comb begin
    neg_d = (state_q == StRun) && cur_q[0] && clk_q;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign bus.clk_o = clk_q | neg_q;
`else
  assign bus.clk_o = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_switch.sv
// Self-checking bench for clk_div_switch: a cycle-by-cycle vector table (inputs applied before
// a posedge, outputs compared 1 ns after it) plus a hand-written reset-during-request sequence.
module tb_clk_div_switch;
  localparam int unsigned CntW = 8;

  logic clk = 1'b0;
  logic rst;

  clk_div_switch_if #(.CNT_W(CntW)) bus ();

  clk_div_switch #(
    .CNT_W     (CntW),
    .DEF_RATIO (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            en;
    logic            req;
    logic [CntW-1:0] ratio;
    logic            clk_o;
    logic            rise;
    logic            busy;
    logic            ack;
    logic [CntW-1:0] cur;
  } vec_t;

  vec_t vec_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic en, input logic req, input int ratio, input logic clk_o,
                     input logic rise, input logic busy, input logic ack, input int cur);
    vec_t v;
    v.en    = en;
    v.req   = req;
    v.ratio = CntW'(ratio);
    v.clk_o = clk_o;
    v.rise  = rise;
    v.busy  = busy;
    v.ack   = ack;
    v.cur   = CntW'(cur);
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic clk_o, input logic rise,
                           input logic busy, input logic ack, input int cur);
    check({tag, ".clk_o"},     idx, int'(bus.clk_o),    int'(clk_o));
    check({tag, ".rise_stb"},  idx, int'(bus.rise_stb), int'(rise));
    check({tag, ".busy"},      idx, int'(bus.busy),     int'(busy));
    check({tag, ".div_ack"},   idx, int'(bus.div_ack),  int'(ack));
    check({tag, ".cur_ratio"}, idx, int'(bus.cur_ratio), cur);
  endtask

  initial begin
    logic prev_clk;
    logic [CntW-1:0] prev_cur;
    logic exp_clk;

    //   en req ratio | clk rise busy ack cur
    // R=4 free run
    add(1, 0, 0, 1, 1, 0, 0, 4);  add(1, 0, 0, 1, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0, 4);  add(1, 0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 1, 1, 0, 0, 4);  add(1, 0, 0, 1, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0, 4);  add(1, 0, 0, 0, 0, 0, 0, 4);
    // request 5 on a boundary cycle: captured only, applied one period later
    add(1, 1, 5, 1, 1, 1, 0, 4);  add(1, 0, 0, 1, 0, 1, 0, 4);
    add(1, 0, 0, 0, 0, 1, 0, 4);  add(1, 0, 0, 0, 0, 1, 0, 4);
    add(1, 0, 0, 1, 1, 0, 1, 5);  add(1, 0, 0, 1, 0, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 5);  add(1, 0, 0, 0, 0, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 5);  add(1, 0, 0, 1, 1, 0, 0, 5);
    add(1, 0, 0, 1, 0, 0, 0, 5);  add(1, 0, 0, 0, 0, 0, 0, 5);
    // ratio 0 clamps to 2; second request (9) while busy is ignored
    add(1, 1, 0, 0, 0, 1, 0, 5);  add(1, 1, 9, 0, 0, 1, 0, 5);
    add(1, 0, 0, 1, 1, 0, 1, 2);  add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 1, 1, 0, 0, 2);  add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 1, 1, 0, 0, 2);  add(1, 0, 0, 0, 0, 0, 0, 2);
    // back to 4
    add(1, 1, 4, 1, 1, 1, 0, 2);  add(1, 0, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 1, 1, 0, 1, 4);
    // 4 -> 7 requested in a high phase; current period completes intact
    add(1, 1, 7, 1, 0, 1, 0, 4);  add(1, 0, 0, 0, 0, 1, 0, 4);
    add(1, 0, 0, 0, 0, 1, 0, 4);  add(1, 0, 0, 1, 1, 0, 1, 7);
    add(1, 0, 0, 1, 0, 0, 0, 7);  add(1, 0, 0, 1, 0, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0, 0, 7);
    // clk_en dropped mid-period: period completes, then STOP
    add(0, 0, 0, 0, 0, 0, 0, 7);  add(0, 0, 0, 0, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 7);  add(0, 0, 0, 0, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 7);  add(0, 0, 0, 0, 0, 0, 0, 7);
    // request while stopped: applied the cycle after capture
    add(0, 1, 4, 0, 0, 1, 0, 7);  add(0, 0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 4);
    // restart: high on the next posedge
    add(1, 0, 0, 1, 1, 0, 0, 4);  add(1, 0, 0, 1, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0, 4);
    // pending request and clk_en=0 at the same boundary: apply, then STOP
    add(1, 1, 3, 0, 0, 1, 0, 4);  add(0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // R=3 run, then same-ratio request still acks
    add(1, 0, 0, 1, 1, 0, 0, 3);  add(1, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 3);  add(1, 0, 0, 1, 1, 0, 0, 3);
    add(1, 1, 3, 0, 0, 1, 0, 3);  add(1, 0, 0, 0, 0, 1, 0, 3);
    add(1, 0, 0, 1, 1, 0, 1, 3);  add(1, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    // leave a request pending during a high phase for the reset sequence
    add(1, 1, 6, 1, 1, 1, 0, 3);

    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.div_req   = 1'b0;
    bus.div_ratio = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    rst = 1'b0;

    prev_clk = 1'b0;
    prev_cur = CntW'(4);
    for (int i = 0; i < vec_q.size(); i++) begin
      bus.clk_en    = vec_q[i].en;
      bus.div_req   = vec_q[i].req;
      bus.div_ratio = vec_q[i].ratio;
      @(posedge clk);
      #1;
      exp_clk = vec_q[i].clk_o;
`ifdef CLK_DIV_ODD_DUTY50_EN
      // negedge extension holds the previous cycle's high level for odd ratios
      exp_clk = exp_clk | (prev_clk & prev_cur[0]);
`endif
      check_all("vec", i, exp_clk, vec_q[i].rise, vec_q[i].busy, vec_q[i].ack,
                int'(vec_q[i].cur));
      prev_clk = vec_q[i].clk_o;
      prev_cur = vec_q[i].cur;
    end

    // Reset in a high phase with a request pending: clk_o drops at once, nothing acks.
    bus.div_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk);
    #1;
    check_all("rst_hold", 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    rst = 1'b0;

    // Normal R=4 operation afterwards, first rise on the first posedge.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_all("post_rst", i, ((i % 4) < 2), ((i % 4) == 0), 1'b0, 1'b0, 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
